// File: rtl/fifo_rd_stream_pkg.sv
// rtl/fifo_rd_stream_pkg.sv - shared FIFO read-side constants and occupancy encodings
package fifo_rd_stream_pkg;

  // Depth of the registered output buffer behind the FIFO read port.
  localparam int BUF_DEPTH = 2;

  // Output-buffer occupancy; the encoding doubles as the m_count value.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } occ_state_t;

  // Words committed to the buffer: those held plus the one whose read is in flight.
  function automatic logic [2:0] occ_fill(input occ_state_t st, input logic inflight);
    return {1'b0, st} + {2'b00, inflight};
  endfunction

endpackage

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read port to valid/ready stream adapter with 2-entry skid buffer
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATASIZE = 8
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rempty,
  output logic                rinc,
  input  logic [DATASIZE-1:0] rdata,
  input  logic                rflush,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DATASIZE-1:0] m_data,
  output logic [1:0]          m_count,
  output logic                ridle
);

  occ_state_t          state;
  occ_state_t          state_nxt;
  logic                inflight;
  logic [DATASIZE-1:0] head_word;
  logic [DATASIZE-1:0] tail_word;
  logic                pop;
  logic                capture;
  logic                room;

  // A flush cancels both the downstream handshake and the word returning from memory.
  assign pop     = m_valid & m_ready & ~rflush;
  assign capture = inflight & ~rflush;

  // Only request another word when it is guaranteed a slot by the time it arrives.
  assign room = occ_fill(state, inflight) < 3'(BUF_DEPTH);

  // The m_ready->rinc path is intentional: a pop frees the slot the new read will land in.
  assign rinc = rrst_n & ~rempty & ~rflush & (room | (m_valid & m_ready));

  // Occupancy state register.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state <= S_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Occupancy moves by one on an unpaired capture or pop; a paired one holds.
  always_comb begin
    state_nxt = state;
    if (rflush) begin
      state_nxt = S_EMPTY;
    end else if (capture && !pop) begin
      case (state)
        S_EMPTY: state_nxt = S_ONE;
        S_ONE:   state_nxt = S_TWO;
        default: state_nxt = state;
      endcase
    end else if (pop && !capture) begin
      case (state)
        S_TWO:   state_nxt = S_ONE;
        S_ONE:   state_nxt = S_EMPTY;
        default: state_nxt = state;
      endcase
    end
  end

  // Stream-side status decoded from registered state only, so m_ready never reaches m_valid.
  always_comb begin
    m_valid = (state != S_EMPTY);
    m_count = state;
    ridle   = (state == S_EMPTY) & ~inflight & rempty;
  end

  // Tracks the registered memory read launched by rinc last cycle.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      inflight <= 1'b0;
    end else begin
      inflight <= rinc & ~rflush;
    end
  end

  // In-order buffer: head_word is the oldest entry and drives m_data directly.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      head_word <= '0;
      tail_word <= '0;
    end else if (!rflush) begin
      if (pop) begin
        if (state == S_TWO) begin
          head_word <= tail_word;
          if (capture) begin
            tail_word <= rdata;
          end
        end else if (capture) begin
          head_word <= rdata;
        end
      end else if (capture) begin
        if (state == S_EMPTY) begin
          head_word <= rdata;
        end else begin
          tail_word <= rdata;
        end
      end
    end
  end

  assign m_data = head_word;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - directed self-checking bench for fifo_rd_stream
module tb_fifo_rd_stream;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic       rempty = 1'b1;
  logic       rinc;
  logic [7:0] rdata = 8'h00;
  logic       rflush;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [1:0] m_count;
  logic       ridle;

  logic [7:0] mem [64];
  int         raddr = 0;
  int         wptr  = 0;

  int checks   = 0;
  int failures = 0;
  int viol_rinc = 0;
  int viol_cnt  = 0;

  int         got_n;
  logic [7:0] got_w [16];
  int         pulses;

  fifo_rd_stream #(.DATASIZE(8)) dut (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .rempty  (rempty),
    .rinc    (rinc),
    .rdata   (rdata),
    .rflush  (rflush),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_count (m_count),
    .ridle   (ridle)
  );

  always #5 rclk = ~rclk;

  // FIFO read side: registered read data, read pointer and registered empty flag.
  always @(posedge rclk) begin
    rdata  <= mem[raddr];
    if (rinc) raddr <= raddr + 1;
    rempty <= (((rinc ? raddr + 1 : raddr)) == wptr);
  end

  // Protocol watch on every cycle.
  always @(negedge rclk) begin
    #2;
    if (rinc && rempty) viol_rinc++;
    if (m_count > 2'd2) viol_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    mem[wptr] = v;
    wptr++;
  endtask

  task automatic drain(input int max_cyc, input bit toggle);
    got_n = 0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge rclk);
      m_ready = toggle ? ~m_ready : 1'b1;
      #1;
      if (m_valid && m_ready && got_n < 16) begin
        got_w[got_n] = m_data;
        got_n++;
      end
    end
    @(negedge rclk);
    m_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    rrst_n  = 1'b0;
    rflush  = 1'b0;
    m_ready = 1'b0;

    // Reset with an empty FIFO.
    @(negedge rclk);
    @(negedge rclk);
    #1;
    check_val("rst_rinc", rinc, 0);
    check_val("rst_valid", m_valid, 0);
    check_val("rst_count", m_count, 0);
    check_val("rst_ridle", ridle, 1);
    check_val("rst_data", m_data, 8'h00);
    @(negedge rclk);
    rrst_n = 1'b1;
    @(negedge rclk);

    // Startup latency and 1 word/cycle streaming.
    @(negedge rclk);
    push(8'h11); push(8'h22); push(8'h33);
    m_ready = 1'b1;
    #1;
    check_val("t2_pre_rinc", rinc, 0);
    @(negedge rclk); #1;
    check_val("t2_c0_rinc", rinc, 1);
    check_val("t2_c0_valid", m_valid, 0);
    @(negedge rclk); #1;
    check_val("t2_c1_rinc", rinc, 1);
    check_val("t2_c1_valid", m_valid, 0);
    @(negedge rclk); #1;
    check_val("t2_c2_valid", m_valid, 1);
    check_val("t2_c2_data", m_data, 8'h11);
    @(negedge rclk); #1;
    check_val("t2_c3_data", m_data, 8'h22);
    check_val("t2_c3_rinc", rinc, 0);
    @(negedge rclk); #1;
    check_val("t2_c4_data", m_data, 8'h33);
    check_val("t2_c4_valid", m_valid, 1);
    @(negedge rclk); #1;
    check_val("t2_c5_valid", m_valid, 0);
    check_val("t2_c5_ridle", ridle, 1);
    m_ready = 1'b0;

    // Backpressure fills exactly two entries, then release.
    @(negedge rclk);
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    pulses = 0;
    #1;
    if (rinc) pulses++;
    for (int c = 0; c < 6; c++) begin
      @(negedge rclk); #1;
      if (rinc) pulses++;
    end
    check_val("t3_pulses", pulses, 2);
    check_val("t3_count", m_count, 2);
    check_val("t3_held", m_data, 8'h11);
    @(negedge rclk); m_ready = 1'b1; #1;
    check_val("t3_r0", m_data, 8'h11);
    @(negedge rclk); #1;
    check_val("t3_r1", m_data, 8'h22);
    @(negedge rclk); #1;
    check_val("t3_r2", m_data, 8'h33);
    @(negedge rclk); #1;
    check_val("t3_r3", m_data, 8'h44);
    check_val("t3_r3_valid", m_valid, 1);
    @(negedge rclk); #1;
    check_val("t3_end_valid", m_valid, 0);
    m_ready = 1'b0;

    // Alternating ready with eight words.
    @(negedge rclk);
    for (int i = 1; i <= 8; i++) push(8'(i));
    drain(40, 1'b1);
    check_val("t4_n", got_n, 8);
    for (int i = 0; i < 8; i++) check_val($sformatf("t4_w%0d", i), got_w[i], 32'(i + 1));

    // Flush with the buffer partly full and a word in flight.
    @(negedge rclk);
    for (int i = 1; i <= 6; i++) push(8'h40 + 8'(i));
    for (int c = 0; c < 5; c++) @(negedge rclk);
    #1;
    check_val("t5_count", m_count, 2);
    check_val("t5_head", m_data, 8'h41);
    @(negedge rclk); m_ready = 1'b1; #1;
    check_val("t5_pop_rinc", rinc, 1);
    @(negedge rclk); m_ready = 1'b0; rflush = 1'b1; #1;
    check_val("t5_fl_rinc", rinc, 0);
    check_val("t5_fl_count", m_count, 1);
    @(negedge rclk); rflush = 1'b0; #1;
    check_val("t5_post_valid", m_valid, 0);
    check_val("t5_post_count", m_count, 0);
    drain(12, 1'b0);
    check_val("t5_n", got_n, 3);
    check_val("t5_w0", got_w[0], 8'h44);
    check_val("t5_w1", got_w[1], 8'h45);
    check_val("t5_w2", got_w[2], 8'h46);

    // Asynchronous reset mid-transfer.
    @(negedge rclk);
    for (int i = 1; i <= 5; i++) push(8'h50 + 8'(i));
    @(negedge rclk);
    @(negedge rclk);
    @(negedge rclk); #1;
    check_val("t6_count", m_count, 1);
    rrst_n = 1'b0;
    #1;
    check_val("t6_rst_valid", m_valid, 0);
    check_val("t6_rst_count", m_count, 0);
    check_val("t6_rst_data", m_data, 8'h00);
    check_val("t6_rst_rinc", rinc, 0);
    check_val("t6_rst_ridle", ridle, 0);
    @(negedge rclk);
    rrst_n = 1'b1;
    drain(12, 1'b0);
    check_val("t6_n", got_n, 3);
    check_val("t6_w0", got_w[0], 8'h53);
    check_val("t6_w1", got_w[1], 8'h54);
    check_val("t6_w2", got_w[2], 8'h55);

    @(negedge rclk);
    check_val("rinc_while_rempty", viol_rinc, 0);
    check_val("count_over_2", viol_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
